signo_exponente_mult: RTL
=========================

// Module: signo_exponente_mult
// PURPOSE
//  Sign/exponent datapath of the floating-point multiplier, parametrised in exponent and mantissa width.
//  Successor to the single-gate sign XOR: it computes result sign, the unnormalised biased exponent sum
//  and special-case classification in a 2-stage valid/ready pipeline.
//  Its output feeds the mantissa-normalisation/rounding stage, which owns the final exponent adjust.
// PARAMETERS
//  EXP_W   8                   exponent field width (8 = single, 11 = double)
//  MAN_W   23                  mantissa field width (stored, no hidden bit)
//  BIAS    2**(EXP_W-1)-1      exponent bias
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous reset, active low
//  in_valid   in   1              operand pair valid
//  in_ready   out  1              block accepts operands this cycle
//  Op_A       in   1+EXP_W+MAN_W  operand A {sign, exp, man}
//  Op_B       in   1+EXP_W+MAN_W  operand B {sign, exp, man}
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts result
//  Signo      out  1              Signo_A ^ Signo_B
//  Exp_Suma   out  EXP_W+2        signed two's-complement expA+expB-BIAS
//  Es_Cero    out  1              result is zero
//  Es_Inf     out  1              result is infinity
//  Es_NaN     out  1              result is NaN
//  Overflow   out  1              Exp_Suma >= 2**EXP_W-1 and no special case
//  Underflow  out  1              Exp_Suma <= 0 and no special case
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids=0, all outputs 0, in_ready=0 while rst_n=0; =1 first cycle after.
//  - Handshake: transfer on in_valid&in_ready / out_valid&out_ready. Output data stable while out_valid&!out_ready.
//  - Stage advance: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational, no bubble).
//  - Latency 2 cycles accept->out_valid; throughput 1/cycle when out_ready=1.
//  - Stage 1 registers: sign XOR, raw exps, per-operand class: zero (exp=0; subnormals flushed to zero),
//    inf (exp=all-ones, man=0), nan (exp=all-ones, man!=0).
//  - Stage 2: Exp_Suma = {00,expA}+{00,expB}-BIAS in EXP_W+2 bits (range -BIAS..2**(EXP_W+1)-2-BIAS, no wrap).
//  - Priority: NaN if either NaN or (inf & zero); else Inf if either inf; else Zero if either zero.
//    Exactly one of Es_NaN/Es_Inf/Es_Cero or none; Overflow/Underflow forced 0 when any is set.
//  - Signo always XOR, including NaN/Inf/Zero (signed zero preserved).
//  - Overflow/Underflow are pre-normalisation hints; downstream makes the final decision.
//  - Simultaneous accept and drain in the same cycle is legal; no data lost or duplicated.
//  - Reset mid-operation: in-flight data discarded, no partial result emitted.
// STRUCTURE
//  - Shared package fp_mult_pkg: class encoding, field-slice functions (sign/exp/man of a word), BIAS constant.
//  - One sub-module: clasifica_fp (combinational zero/inf/nan decode of one operand), instantiated twice.
//  - Pipeline registers and handshake logic live in this module; no FSM beyond per-stage valid bits.
// TESTING (EXP_W=8, MAN_W=23)
//  1 0x40000000 x 0xC0400000 -> 2 cycles later out_valid=1, Signo=1, Exp_Suma=129, all flags 0.
//  2 0x00000000 x 0x7F800000 -> Es_NaN=1, Es_Inf=0, Es_Cero=0, Overflow=0; 0x80000000 x 0x3F800000 -> Es_Cero=1, Signo=1.
//  3 0x7F000000 x 0x7F000000 -> Exp_Suma=381, Overflow=1; 0x00800000 x 0x00800000 -> Exp_Suma=-125, Underflow=1.
//  4 out_ready=0 for 4 cycles, in_valid=1 each cycle -> exactly 2 accepted, in_ready=0 from 3rd cycle,
//    outputs held; out_ready=1 -> results drain in order, 1 per cycle, none lost.
//  5 Back-to-back 100 random pairs, out_ready=1 -> in_ready never drops, results match model in order.
//  6 rst_n pulled low with both stages full -> out_valid=0 immediately; after release no stale result.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared floating-point multiplier definitions: operand class encoding, bias and field slicing.
package fp_mult_pkg;

  typedef enum logic [1:0] {
    CLS_FINITE = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_e;

  // Widest operand word the slicing helpers accept; callers zero-extend into it.
  localparam int FP_MAX_W = 128;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic sign_of(input logic [FP_MAX_W-1:0] w, input int exp_w, input int man_w);
    return w[exp_w + man_w];
  endfunction

  function automatic logic [FP_MAX_W-1:0] exp_of(input logic [FP_MAX_W-1:0] w, input int exp_w,
                                                 input int man_w);
    return (w >> man_w) & ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] man_of(input logic [FP_MAX_W-1:0] w, input int man_w);
    return w & ((FP_MAX_W'(1) << man_w) - FP_MAX_W'(1));
  endfunction

endpackage

// File: rtl/signo_exponente_mult_if.sv
// Operand/result handshake bundle of the sign/exponent multiplier stage.
interface signo_exponente_mult_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            Op_A;
  logic [W-1:0]            Op_B;
  logic                    out_valid;
  logic                    out_ready;
  logic                    Signo;
  logic signed [EXP_W+1:0] Exp_Suma;
  logic                    Es_Cero;
  logic                    Es_Inf;
  logic                    Es_NaN;
  logic                    Overflow;
  logic                    Underflow;

  modport master (
    output in_valid, Op_A, Op_B, out_ready,
    input  in_ready, out_valid, Signo, Exp_Suma, Es_Cero, Es_Inf, Es_NaN, Overflow, Underflow
  );

  modport slave (
    input  in_valid, Op_A, Op_B, out_ready,
    output in_ready, out_valid, Signo, Exp_Suma, Es_Cero, Es_Inf, Es_NaN, Overflow, Underflow
  );

endinterface

// File: rtl/clasifica_fp.sv
// Combinational zero/inf/nan decode of one operand; subnormals are treated as zero.
module clasifica_fp
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] man_i,
  output fp_class_e        cls_o
);

  always_comb begin
    cls_o = CLS_FINITE;
    if (exp_i == '0) begin
      cls_o = CLS_ZERO;
    end else if (&exp_i) begin
      cls_o = (man_i == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/signo_exponente_mult.sv
// Sign, unnormalised biased exponent sum and special-case flags; 2-stage valid/ready pipeline,
// latency 2, 1 result/cycle, in_ready falls only when both stages are full and output is stalled.
module signo_exponente_mult
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = bias_of(EXP_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  signo_exponente_mult_if.slave  bus
);

  localparam int SW = EXP_W + 2;
  localparam logic [SW-1:0] OVF_LIM = SW'((1 << EXP_W) - 1);

  logic [FP_MAX_W-1:0] op_a_w, op_b_w;
  logic [EXP_W-1:0]    exp_a, exp_b;
  logic [MAN_W-1:0]    man_a, man_b;
  fp_class_e           cls_a, cls_b;
  logic                adv1, adv2;

  logic             v1_q, v1_d, sign1_q, sign1_d;
  logic [EXP_W-1:0] expa1_q, expa1_d, expb1_q, expb1_d;
  fp_class_e        cls_a1_q, cls_a1_d, cls_b1_q, cls_b1_d;

  logic          v2_q, v2_d, sign2_q, sign2_d;
  logic [SW-1:0] exp2_q, exp2_d;
  logic          zero2_q, zero2_d, inf2_q, inf2_d, nan2_q, nan2_d, ovf2_q, ovf2_d, unf2_q, unf2_d;

  logic [SW-1:0] sum;
  logic          is_nan, is_inf, is_zero, special;

  assign op_a_w = FP_MAX_W'(bus.Op_A);
  assign op_b_w = FP_MAX_W'(bus.Op_B);
  assign exp_a  = EXP_W'(exp_of(op_a_w, EXP_W, MAN_W));
  assign exp_b  = EXP_W'(exp_of(op_b_w, EXP_W, MAN_W));
  assign man_a  = MAN_W'(man_of(op_a_w, MAN_W));
  assign man_b  = MAN_W'(man_of(op_b_w, MAN_W));

  clasifica_fp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_clas_a (.exp_i(exp_a), .man_i(man_a), .cls_o(cls_a));
  clasifica_fp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_clas_b (.exp_i(exp_b), .man_i(man_b), .cls_o(cls_b));

  assign adv2         = !v2_q || bus.out_ready;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = rst_n && adv1;

  always_comb begin
    v1_d     = v1_q;
    sign1_d  = sign1_q;
    expa1_d  = expa1_q;
    expb1_d  = expb1_q;
    cls_a1_d = cls_a1_q;
    cls_b1_d = cls_b1_q;
    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        sign1_d  = sign_of(op_a_w, EXP_W, MAN_W) ^ sign_of(op_b_w, EXP_W, MAN_W);
        expa1_d  = exp_a;
        expb1_d  = exp_b;
        cls_a1_d = cls_a;
        cls_b1_d = cls_b;
      end
    end
  end

  // Zero-extended sum fits in EXP_W+2 bits, so the modular subtract yields the exact signed value.
  always_comb begin
    sum     = SW'({2'b00, expa1_q}) + SW'({2'b00, expb1_q}) - SW'(BIAS);
    is_nan  = (cls_a1_q == CLS_NAN) || (cls_b1_q == CLS_NAN) ||
              ((cls_a1_q == CLS_INF) && (cls_b1_q == CLS_ZERO)) ||
              ((cls_a1_q == CLS_ZERO) && (cls_b1_q == CLS_INF));
    is_inf  = !is_nan && ((cls_a1_q == CLS_INF) || (cls_b1_q == CLS_INF));
    is_zero = !is_nan && !is_inf && ((cls_a1_q == CLS_ZERO) || (cls_b1_q == CLS_ZERO));
    special = is_nan || is_inf || is_zero;

    v2_d    = v2_q;
    sign2_d = sign2_q;
    exp2_d  = exp2_q;
    zero2_d = zero2_q;
    inf2_d  = inf2_q;
    nan2_d  = nan2_q;
    ovf2_d  = ovf2_q;
    unf2_d  = unf2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        exp2_d  = sum;
        zero2_d = is_zero;
        inf2_d  = is_inf;
        nan2_d  = is_nan;
        ovf2_d  = !special && ($signed(sum) >= $signed(OVF_LIM));
        unf2_d  = !special && (sum[SW-1] || (sum == '0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      expa1_q  <= '0;
      expb1_q  <= '0;
      cls_a1_q <= CLS_FINITE;
      cls_b1_q <= CLS_FINITE;
      v2_q     <= 1'b0;
      sign2_q  <= 1'b0;
      exp2_q   <= '0;
      zero2_q  <= 1'b0;
      inf2_q   <= 1'b0;
      nan2_q   <= 1'b0;
      ovf2_q   <= 1'b0;
      unf2_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      sign1_q  <= sign1_d;
      expa1_q  <= expa1_d;
      expb1_q  <= expb1_d;
      cls_a1_q <= cls_a1_d;
      cls_b1_q <= cls_b1_d;
      v2_q     <= v2_d;
      sign2_q  <= sign2_d;
      exp2_q   <= exp2_d;
      zero2_q  <= zero2_d;
      inf2_q   <= inf2_d;
      nan2_q   <= nan2_d;
      ovf2_q   <= ovf2_d;
      unf2_q   <= unf2_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.Signo     = sign2_q;
  assign bus.Exp_Suma  = exp2_q;
  assign bus.Es_Cero   = zero2_q;
  assign bus.Es_Inf    = inf2_q;
  assign bus.Es_NaN    = nan2_q;
  assign bus.Overflow  = ovf2_q;
  assign bus.Underflow = unf2_q;

endmodule
